// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request ports, memory bus and status lines of the
// unified-memory arbiter. slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [DATA_W-1:0] if_data;
   logic              dm_rd;
   logic              dm_wr;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_done;
   logic [DATA_W-1:0] dm_rdata;
   logic              halt;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_dm;
   logic              err;

   modport slave (
      input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
      output if_done, if_data, dm_done, dm_rdata, mem_en, mem_wr, mem_addr,
             mem_wdata, stall_if, stall_dm, err
   );

   modport master (
      output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
      input  if_done, if_data, dm_done, dm_rdata, mem_en, mem_wr, mem_addr,
             mem_wdata, stall_if, stall_dm, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported fixed-latency memory between instruction
// fetch and the data stage. Data has fixed priority; each access runs
// grant -> issue -> wait -> response, one access per MEM_LAT+3 cycles.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam logic [2:0] LAT = 3'(MEM_LAT);

   typedef enum logic [2:0] {IDLE, ISSUE_IF, ISSUE_DM, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              own_dm_q, own_dm_d;
   logic              wr_q, wr_d;
   logic              abort_q, abort_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              fetch_busy, data_busy;
   logic              issue, if_done, dm_done;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         own_dm_q   <= 1'b0;
         wr_q       <= 1'b0;
         abort_q    <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_data_q  <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         own_dm_q   <= own_dm_d;
         wr_q       <= wr_d;
         abort_q    <= abort_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_data_q  <= if_data_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // Next state: grant, latency countdown, response capture and protocol checks
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      own_dm_d   = own_dm_q;
      wr_d       = wr_q;
      abort_d    = abort_q;
      err_d      = err_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_data_d  = if_data_q;
      dm_rdata_d = dm_rdata_q;
      fetch_busy = (state_q == ISSUE_IF) || (state_q == WAIT && !own_dm_q);
      data_busy  = (state_q == ISSUE_DM) || (state_q == WAIT && own_dm_q);

      unique case (state_q)
         IDLE: begin
            if (bus.dm_rd && bus.dm_wr) begin
               err_d = 1'b1;
            end else if (bus.dm_rd || bus.dm_wr) begin
               state_d  = ISSUE_DM;
               own_dm_d = 1'b1;
               wr_d     = bus.dm_wr;
               abort_d  = 1'b0;
               addr_d   = bus.dm_addr;
               wdata_d  = bus.dm_wdata;
            end else if (bus.if_req && !bus.halt) begin
               state_d  = ISSUE_IF;
               own_dm_d = 1'b0;
               wr_d     = 1'b0;
               abort_d  = 1'b0;
               addr_d   = bus.if_addr;
            end
         end
         ISSUE_IF, ISSUE_DM: begin
            state_d = WAIT;
            cnt_d   = LAT;
         end
         WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = RESP;
               if (own_dm_q) begin
                  if (!wr_q) dm_rdata_d = bus.mem_rdata;
               end else if (!abort_q && bus.if_req) begin
                  if_data_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A flushed fetch still runs to completion but is never reported
      if (fetch_busy && !bus.if_req) abort_d = 1'b1;

      if (data_busy && ((wr_q ? !bus.dm_wr : !bus.dm_rd) ||
                        (bus.dm_addr != addr_q) || (bus.dm_wdata != wdata_q)))
         err_d = 1'b1;
   end

   // Outputs decoded from state and registered copies
   always_comb begin
      issue         = (state_q == ISSUE_IF) || (state_q == ISSUE_DM);
      if_done       = (state_q == RESP) && !own_dm_q && !abort_q;
      dm_done       = (state_q == RESP) && own_dm_q;
      bus.mem_en    = issue;
      bus.mem_wr    = issue && wr_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.if_done   = if_done;
      bus.dm_done   = dm_done;
      bus.if_data   = if_data_q;
      bus.dm_rdata  = dm_rdata_q;
      bus.stall_if  = bus.if_req && !if_done;
      bus.stall_dm  = (bus.dm_rd || bus.dm_wr) && !dm_done;
      bus.err       = err_q;
   end
endmodule
